// File: rtl/clock_select_ctrl.sv
// clock_select_ctrl: decides per CPU cycle whether the CPU runs on the HS or LS clock and
// stalls the CPU while a switch is in flight. Optional build macro FORCE_SLOW_EN adds force_slow_ip.

module clock_select_ctrl #(
    parameter logic [15:0] IO_BASE     = 16'hFC00,
    parameter logic [15:0] IO_TOP      = 16'hFEFF,
    parameter int          SLOW_HOLD   = 4,
    parameter int          SYNC_STAGES = 2,
    parameter int          SWITCH_TMO  = 31
) (
    input  logic        ck_ip,
    input  logic        reset_ip,
    input  logic        cpu_valid_ip,
    input  logic [15:0] cpu_addr_ip,
    input  logic        selected_hs_ip,
    input  logic        selected_ls_ip,
`ifdef FORCE_SLOW_EN
    input  logic        force_slow_ip,
`endif
    output logic        select_hs_op,
    output logic        rdy_op,
    output logic        fast_op,
    output logic        err_op
);

    localparam int HW = $clog2(SLOW_HOLD + 1);
    localparam int TW = $clog2(SWITCH_TMO + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(SLOW_HOLD);
    localparam logic [TW-1:0] TMO_MAX   = TW'(SWITCH_TMO);
    localparam logic [TW-1:0] TMO_LAST  = TW'(SWITCH_TMO - 1);

    typedef enum logic [1:0] {
        ST_FAST    = 2'd0,
        ST_TO_SLOW = 2'd1,
        ST_SLOW    = 2'd2,
        ST_TO_FAST = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [HW-1:0]          hold_cnt_r;
    logic [HW-1:0]          hold_nxt_s;
    logic [TW-1:0]          tmo_cnt_r;
    logic [TW-1:0]          tmo_nxt_s;
    logic [TW-1:0]          tmo_inc_s;
    logic                   err_r;
    logic                   err_nxt_s;
    logic                   fast_r;
    logic [SYNC_STAGES-1:0] hs_sync_r;
    logic [SYNC_STAGES-1:0] ls_sync_r;
    logic                   hs_s;
    logic                   ls_s;
    logic                   hs_ok_s;
    logic                   ls_ok_s;
    logic                   slow_acc_s;
    logic                   tmo_hit_s;
    logic                   select_hs_s;
    logic                   rdy_s;

    function automatic logic in_io_window(input logic [15:0] addr);
        return (addr >= IO_BASE) && (addr <= IO_TOP);
    endfunction

`ifdef FORCE_SLOW_EN
    assign slow_acc_s = (cpu_valid_ip & in_io_window(cpu_addr_ip)) | force_slow_ip;
`else
    assign slow_acc_s = cpu_valid_ip & in_io_window(cpu_addr_ip);
`endif

    // Resynchronise switch status; reset state claims LS so the CPU starts slow.
    always_ff @(posedge ck_ip or posedge reset_ip) begin
        if (reset_ip) begin
            hs_sync_r <= {SYNC_STAGES{1'b0}};
            ls_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            hs_sync_r <= {hs_sync_r[SYNC_STAGES-2:0], selected_hs_ip};
            ls_sync_r <= {ls_sync_r[SYNC_STAGES-2:0], selected_ls_ip};
        end
    end

    assign hs_s    = hs_sync_r[SYNC_STAGES-1];
    assign ls_s    = ls_sync_r[SYNC_STAGES-1];
    assign hs_ok_s = hs_s & ~ls_s;
    assign ls_ok_s = ls_s & ~hs_s;

    // The abort fires on the SWITCH_TMO-th cycle spent in a transition state.
    assign tmo_inc_s = (tmo_cnt_r == TMO_MAX) ? tmo_cnt_r : (tmo_cnt_r + TW'(1));
    assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);

    // Next-state and per-cycle select/ready decode.
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_cnt_r;
        tmo_nxt_s   = tmo_cnt_r;
        err_nxt_s   = err_r;
        select_hs_s = 1'b0;
        rdy_s       = 1'b1;
        case (state_r)
            ST_FAST: begin
                select_hs_s = ~slow_acc_s;
                rdy_s       = ~slow_acc_s;
                if (slow_acc_s) begin
                    state_nxt_s = ST_TO_SLOW;
                    tmo_nxt_s   = {TW{1'b0}};
                end else begin
                    state_nxt_s = ST_FAST;
                end
            end
            ST_TO_SLOW: begin
                select_hs_s = 1'b0;
                rdy_s       = 1'b0;
                tmo_nxt_s   = tmo_inc_s;
                if (ls_ok_s) begin
                    state_nxt_s = ST_SLOW;
                    hold_nxt_s  = HOLD_INIT;
                end else if (tmo_hit_s) begin
                    state_nxt_s = ST_SLOW;
                    hold_nxt_s  = HOLD_INIT;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_TO_SLOW;
                end
            end
            ST_SLOW: begin
                select_hs_s = 1'b0;
                rdy_s       = 1'b1;
                if (slow_acc_s) begin
                    hold_nxt_s = HOLD_INIT;
                end else if (hold_cnt_r == {HW{1'b0}}) begin
                    state_nxt_s = ST_TO_FAST;
                    tmo_nxt_s   = {TW{1'b0}};
                end else begin
                    hold_nxt_s = hold_cnt_r - HW'(1);
                end
            end
            ST_TO_FAST: begin
                select_hs_s = ~slow_acc_s;
                rdy_s       = ~slow_acc_s;
                tmo_nxt_s   = tmo_inc_s;
                // A new slow access restarts the switch back towards LS.
                if (slow_acc_s) begin
                    state_nxt_s = ST_TO_SLOW;
                    tmo_nxt_s   = {TW{1'b0}};
                end else if (hs_ok_s) begin
                    state_nxt_s = ST_FAST;
                end else if (tmo_hit_s) begin
                    state_nxt_s = ST_SLOW;
                    hold_nxt_s  = HOLD_INIT;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_TO_FAST;
                end
            end
            default: begin
                state_nxt_s = ST_SLOW;
                hold_nxt_s  = HOLD_INIT;
                tmo_nxt_s   = {TW{1'b0}};
            end
        endcase
    end

    // State, counters and registered status flags.
    always_ff @(posedge ck_ip or posedge reset_ip) begin
        if (reset_ip) begin
            state_r    <= ST_SLOW;
            hold_cnt_r <= HOLD_INIT;
            tmo_cnt_r  <= {TW{1'b0}};
            err_r      <= 1'b0;
            fast_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            tmo_cnt_r  <= tmo_nxt_s;
            err_r      <= err_nxt_s;
            fast_r     <= (state_nxt_s == ST_FAST);
        end
    end

    assign select_hs_op = select_hs_s;
    assign rdy_op       = rdy_s;
    assign fast_op      = fast_r;
    assign err_op       = err_r;

endmodule

// File: tb/tb_clock_select_ctrl.sv
// Self-checking bench for clock_select_ctrl: behavioural mode model plus a delayed clock-switch model.

module tb_clock_select_ctrl;

    localparam int          SLOW_HOLD   = 4;
    localparam int          SYNC_STAGES = 2;
    localparam int          SWITCH_TMO  = 31;
    localparam logic [15:0] IO_BASE     = 16'hFC00;
    localparam logic [15:0] IO_TOP      = 16'hFEFF;
    localparam int M_FAST = 0, M_TO_SLOW = 1, M_SLOW = 2, M_TO_FAST = 3;

    logic        ck = 1'b0;
    logic        rst;
    logic        valid;
    logic [15:0] addr;
    logic        sel_hs_in;
    logic        sel_ls_in;
    logic        select_hs;
    logic        rdy;
    logic        fast;
    logic        err;
`ifdef FORCE_SLOW_EN
    logic        force_slow = 1'b0;
`endif

    always #5 ck = ~ck;

    clock_select_ctrl dut (
        .ck_ip          (ck),
        .reset_ip       (rst),
        .cpu_valid_ip   (valid),
        .cpu_addr_ip    (addr),
        .selected_hs_ip (sel_hs_in),
        .selected_ls_ip (sel_ls_in),
`ifdef FORCE_SLOW_EN
        .force_slow_ip  (force_slow),
`endif
        .select_hs_op   (select_hs),
        .rdy_op         (rdy),
        .fast_op        (fast),
        .err_op         (err)
    );

    // Model state
    int mode;
    int idle_run;
    int sw_cycles;
    bit m_err;
    bit sync_hs[SYNC_STAGES];
    bit sync_ls[SYNC_STAGES];
    // Clock-switch model: reports the requested clock sw_dly cycles later
    bit sel_hist[8];
    int sw_dly   = 3;
    int sw_fault = 0;   // 0 normal, 1 LS never reported, 2 HS never reported

    int vectors     = 0;
    int miscompares = 0;
    logic d_sel, d_rdy, d_fast, d_err;

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit slow_now();
        bit s;
        s = valid && (addr >= IO_BASE) && (addr <= IO_TOP);
`ifdef FORCE_SLOW_EN
        s = s || force_slow;
`endif
        return s;
    endfunction

    task automatic model_reset();
        mode      = M_SLOW;
        idle_run  = 0;
        sw_cycles = 0;
        m_err     = 1'b0;
        for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_hs[i] = 1'b0;
            sync_ls[i] = 1'b1;
        end
    endtask

    task automatic model_step(input bit slow);
        bit hs_ok, ls_ok;
        hs_ok = sync_hs[SYNC_STAGES-1] && !sync_ls[SYNC_STAGES-1];
        ls_ok = sync_ls[SYNC_STAGES-1] && !sync_hs[SYNC_STAGES-1];
        case (mode)
            M_FAST: if (slow) begin mode = M_TO_SLOW; sw_cycles = 0; end
            M_TO_SLOW: begin
                sw_cycles++;
                if (ls_ok) begin mode = M_SLOW; idle_run = 0; end
                else if (sw_cycles == SWITCH_TMO) begin m_err = 1'b1; mode = M_SLOW; idle_run = 0; end
            end
            M_SLOW: begin
                if (slow) idle_run = 0;
                else begin
                    idle_run++;
                    if (idle_run == SLOW_HOLD + 1) begin mode = M_TO_FAST; sw_cycles = 0; end
                end
            end
            M_TO_FAST: begin
                sw_cycles++;
                if (slow) begin mode = M_TO_SLOW; sw_cycles = 0; end
                else if (hs_ok) mode = M_FAST;
                else if (sw_cycles == SWITCH_TMO) begin m_err = 1'b1; mode = M_SLOW; idle_run = 0; end
            end
            default: mode = M_SLOW;
        endcase
        for (int i = SYNC_STAGES - 1; i > 0; i--) begin
            sync_hs[i] = sync_hs[i-1];
            sync_ls[i] = sync_ls[i-1];
        end
        sync_hs[0] = sel_hs_in;
        sync_ls[0] = sel_ls_in;
    endtask

    // One CPU cycle: drive at negedge, compare outputs, advance the model at posedge.
    task automatic tick(input bit v, input logic [15:0] a, input bit r);
        bit slow, e_sel, e_rdy;
        @(negedge ck);
        rst       = r;
        valid     = v;
        addr      = a;
        sel_hs_in = (sw_fault == 2) ? 1'b0 : sel_hist[sw_dly-1];
        sel_ls_in = (sw_fault == 1) ? 1'b0 : !sel_hist[sw_dly-1];
        #1;
        if (r) model_reset();
        slow  = slow_now();
        e_sel = ((mode == M_FAST) || (mode == M_TO_FAST)) && !slow;
        e_rdy = (mode == M_SLOW) || (((mode == M_FAST) || (mode == M_TO_FAST)) && !slow);
        d_sel = select_hs; d_rdy = rdy; d_fast = fast; d_err = err;
        check_bit("select_hs", d_sel, e_sel);
        check_bit("rdy", d_rdy, e_rdy);
        check_bit("fast", d_fast, mode == M_FAST);
        check_bit("err", d_err, m_err);
        for (int i = 7; i > 0; i--) sel_hist[i] = sel_hist[i-1];
        sel_hist[0] = e_sel;
        @(posedge ck);
        if (!r) model_step(slow);
    endtask

    task automatic wait_mode(input int target, input string name);
        int n;
        n = 0;
        while (mode != target && n < 100) begin
            tick(1'b0, 16'h0000, 1'b0);
            n++;
        end
        if (mode != target) check_int(name, mode, target);
    endtask

    initial begin
        int n;
        int rst_left;
        for (int i = 0; i < 8; i++) sel_hist[i] = 1'b0;
        model_reset();
        valid = 1'b0; addr = 16'h0000; rst = 1'b1;
        sel_hs_in = 1'b0; sel_ls_in = 1'b1;

        // Reset values
        repeat (3) tick(1'b0, 16'h0000, 1'b1);
        check_bit("rst_select_hs", d_sel, 1'b0);
        check_bit("rst_rdy", d_rdy, 1'b1);
        check_bit("rst_fast", d_fast, 1'b0);
        check_bit("rst_err", d_err, 1'b0);

        // Idle after reset: fast after SLOW_HOLD+1 idles, TO_FAST, 3-cycle switch, 2 sync flops
        n = 0;
        do begin tick(1'b0, 16'h0000, 1'b0); n++; end while (!d_fast && n < 60);
        check_int("boot_to_fast_cycles", n, 12);
        check_bit("boot_err", d_err, 1'b0);

        // Slow access from FAST stalls in the same cycle
        tick(1'b1, 16'hFE40, 1'b0);
        check_bit("acc_same_cycle_sel", d_sel, 1'b0);
        check_bit("acc_same_cycle_rdy", d_rdy, 1'b0);
        n = 0;
        do begin tick(1'b0, 16'h0000, 1'b0); n++; end while (!d_rdy && n < 60);
        check_int("stall_release_cycles", n, 6);
        check_int("mode_after_stall", mode, M_SLOW);

        // Window edges just outside the I/O range never stall
        wait_mode(M_FAST, "reach_fast_edges");
        tick(1'b1, 16'hFBFF, 1'b0);
        check_bit("edge_fbff_sel", d_sel, 1'b1);
        check_bit("edge_fbff_rdy", d_rdy, 1'b1);
        tick(1'b1, 16'hFF00, 1'b0);
        check_bit("edge_ff00_sel", d_sel, 1'b1);
        check_bit("edge_ff00_rdy", d_rdy, 1'b1);

        // Slow access every third cycle keeps the CPU slow
        tick(1'b1, 16'hFC00, 1'b0);
        wait_mode(M_SLOW, "reach_slow_periodic");
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, 16'hFEFF, 1'b0);
            tick(1'b0, 16'h0000, 1'b0);
            tick(1'b0, 16'h0000, 1'b0);
            check_bit("periodic_stays_slow", d_sel, 1'b0);
        end
        tick(1'b1, 16'hFEFF, 1'b0);
        repeat (5) tick(1'b0, 16'h0000, 1'b0);
        check_bit("hold_last_slow_cycle", d_sel, 1'b0);
        tick(1'b0, 16'h0000, 1'b0);
        check_bit("hold_expired_to_fast", d_sel, 1'b1);

        // Slow access in the very cycle hs_ok appears wins over completion
        repeat (4) tick(1'b0, 16'h0000, 1'b0);
        tick(1'b1, 16'hFD00, 1'b0);
        check_bit("race_rdy", d_rdy, 1'b0);
        check_bit("race_sel", d_sel, 1'b0);
        tick(1'b0, 16'h0000, 1'b0);
        check_bit("race_fast_stays_0", d_fast, 1'b0);
        check_bit("race_in_to_slow_rdy", d_rdy, 1'b0);

        // Switch never reports LS: timeout, sticky error, back to SLOW
        wait_mode(M_FAST, "reach_fast_tmo");
        sw_fault = 1;
        tick(1'b1, 16'hFC10, 1'b0);
        n = 0;
        do begin tick(1'b0, 16'h0000, 1'b0); n++; end while (!d_err && n < 80);
        check_int("timeout_cycles", n, SWITCH_TMO + 1);
        check_bit("timeout_slow_rdy", d_rdy, 1'b1);
        check_bit("timeout_slow_sel", d_sel, 1'b0);
        repeat (20) tick(1'b0, 16'h0000, 1'b0);
        check_bit("err_sticky", d_err, 1'b1);
        sw_fault = 0;

        // Randomised traffic, switch faults/delays and reset pulses
        rst_left = 2;
        for (int c = 0; c < 4000; c++) begin
            logic [15:0] a;
            int pick;
            if (c % 400 == 0) begin
                sw_dly   = $urandom_range(1, 4);
                sw_fault = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
            end
            if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
            pick = $urandom_range(0, 7);
            case (pick)
                0: a = 16'hFBFF;
                1: a = 16'hFC00;
                2: a = 16'hFEFF;
                3: a = 16'hFF00;
                4: a = 16'hFC00 + 16'($urandom_range(0, 767));
                default: a = 16'($urandom);
            endcase
`ifdef FORCE_SLOW_EN
            force_slow = ($urandom_range(0, 31) == 0);
`endif
            tick($urandom_range(0, 5) == 0, a, rst_left > 0);
            if (rst_left > 0) rst_left--;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
